lane_hit_judge: RTL and testbench
=================================

# lane_hit_judge

Per-lane hit judge for the falling-block piano game: the consumer end of the lane block-position interface. It watches a lane's `block_h` position, arms when a new block enters at the top, and turns the player's key press into a hit, perfect or miss verdict. It also maintains per-lane score and combo counters. One instance sits beside each lane's block generator and feeds the score/display logic.

## Interface
- `TOP`, 120: block_h value a new block is loaded with.
- `BOTTOM`, 720: block_h value meaning no block visible / lane empty.
- `HIT_LO`, 600: lowest block_h (inclusive) accepted as a hit.
- `HIT_HI`, 700: highest block_h (inclusive) accepted as a hit.
- `PERF_LO`, 640: lowest block_h (inclusive) of the perfect sub-window.
- `PERF_HI`, 670: highest block_h (inclusive) of the perfect sub-window.

Ports:
- `clk`  in  1  game tick (same tick that advances block_h).
- `rst_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous clear, same effect as reset.
- `stop_or_endgame`  in  1  freeze: no judging, counters hold.
- `block_h`  in  10  lane block position from the block generator.
- `key`  in  1  raw lane key, asynchronous to clk, active-high.
- `hit_pulse`  out  1  one-cycle pulse on any accepted hit, perfect included.
- `perfect_pulse`  out  1  one-cycle pulse, accompanies hit_pulse when inside the perfect window.
- `miss_pulse`  out  1  one-cycle pulse on a miss.
- `score`  out  16  accumulated score, saturating.
- `combo`  out  8  current consecutive-hit count, saturating.
- `max_combo`  out  8  highest combo since reset/restart.

## Operation
- Key path: 2-flop synchronizer, then a third flop for edge detect. `key_rise` = s2 & ~s3.
  - The flops keep tracking while frozen, so a press held across a pause does not fire on resume.
- Arrival detect: register `prev_h`. `arrival` = (block_h == TOP) && (prev_h != TOP).
- FSM states:
  - IDLE: no block pending.
  - ARMED: block falling, not yet judged.
  - JUDGED: verdict given, waiting for the next block.
- Transitions (all gated by ~stop_or_endgame except arrival):
  - Any state + arrival -> ARMED. If the state was ARMED, first issue miss_pulse for the unjudged block in that same cycle.
  - ARMED + key_rise + HIT_LO ≤ block_h ≤ HIT_HI -> JUDGED, hit_pulse.
    - perfect_pulse as well if PERF_LO ≤ block_h ≤ PERF_HI.
  - ARMED + key_rise + block_h < HIT_LO (early press) -> JUDGED, miss_pulse.
  - ARMED + block_h > HIT_HI without a valid press -> JUDGED, miss_pulse. This includes block_h == BOTTOM.
  - key_rise in IDLE or JUDGED: ignored, no penalty.
- Counters:
  - Hit adds +1 to score; perfect adds +2 (not +3). Score saturates at 16'hFFFF.
  - Hit increments combo, saturating at 255. Miss clears combo to 0.
  - max_combo is updated to combo's next value whenever that exceeds it.
- Freeze: when stop_or_endgame=1, the FSM, pulses (held 0) and counters all hold.
  - An arrival while frozen still moves the FSM to ARMED; the implied miss is still counted, keeping block accounting exact.
- Reset/restart: FSM=IDLE, prev_h=BOTTOM, sync flops=0, all outputs 0. Restart takes precedence over every other event in its cycle.

## Timing
- Pulses and counters are registered; every output changes only on a clk edge.
- Key latency: key high before edge k -> s1 at k, s2 at k+1, verdict registered at k+2.
  - The verdict window compare uses the block_h present at edge k+2.
  - hit/perfect/miss pulse high for exactly the cycle after k+2.
- The late-miss check uses the block_h at the edge where it first exceeds HIT_HI. The pulse follows one cycle later.
- score/combo/max_combo update on the same edge as the pulse.
- Window boundaries are inclusive on both ends. Comparisons are unsigned 10-bit.
- At most one verdict per block. A key_rise on the same edge as a late miss loses: miss wins.
- Arrival and key_rise on the same edge: the arrival is processed and the key is ignored, since the new block is at TOP and outside the window.

## Test plan
- Reset, block_h ramps 120→720 with no key -> exactly one miss_pulse, the cycle after block_h=701 is sampled; combo=0, score=0.
- Key rise so that block_h=650 at the judging edge -> hit_pulse and perfect_pulse; score=2, combo=1, max_combo=1.
- Key rise judged at block_h=600 and, on the next block, at 700 -> two hit_pulse without perfect_pulse; score +1 each. Judged at 599 -> miss_pulse, combo cleared.
- 256 consecutive perfect hits -> combo and max_combo stick at 255, score=512. A following miss gives combo=0, max_combo=255.
- New block arrival (block_h 450→120) while ARMED -> miss_pulse that cycle, then re-armed. A key press held through a stop_or_endgame pause gives no verdict on resume.
- restart asserted mid-fall with score=10 -> all outputs 0, FSM IDLE. Async rst_n low clears outputs without a clk edge.

Source files
------------

// File: rtl/lane_hit_judge_if.sv
// rtl/lane_hit_judge_if.sv - lane block-position and verdict bundle between lane driver and hit judge
interface lane_hit_judge_if;
  logic        restart;
  logic        stop_or_endgame;
  logic [9:0]  block_h;
  logic        key;
  logic        hit_pulse;
  logic        perfect_pulse;
  logic        miss_pulse;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  modport master (
    output restart, stop_or_endgame, block_h, key,
    input  hit_pulse, perfect_pulse, miss_pulse, score, combo, max_combo
  );

  modport slave (
    input  restart, stop_or_endgame, block_h, key,
    output hit_pulse, perfect_pulse, miss_pulse, score, combo, max_combo
  );
endinterface

// File: rtl/lane_hit_judge.sv
// rtl/lane_hit_judge.sv - per-lane hit/perfect/miss judge with score and combo counters
module lane_hit_judge #(
  parameter logic [9:0] TOP     = 10'd120,
  parameter logic [9:0] BOTTOM  = 10'd720,
  parameter logic [9:0] HIT_LO  = 10'd600,
  parameter logic [9:0] HIT_HI  = 10'd700,
  parameter logic [9:0] PERF_LO = 10'd640,
  parameter logic [9:0] PERF_HI = 10'd670
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_hit_judge_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_JUDGED = 2'd2;

  logic [1:0]  state, state_nx;
  logic [9:0]  prev_h;
  logic        s1, s2, s3;
  logic        hit_q, perf_q, miss_q;
  logic [15:0] score_q, score_nx;
  logic [7:0]  combo_q, combo_nx, max_q, max_nx;
  logic [16:0] score_sum;
  logic        arrival, key_rise, frz;
  logic        hit_evt, perf_evt, miss_evt;
  logic        in_hit, in_perf;

  assign arrival  = (bus.block_h == TOP) && (prev_h != TOP);
  assign key_rise = s2 & ~s3;
  assign frz      = bus.stop_or_endgame;
  assign in_hit   = (bus.block_h >= HIT_LO) && (bus.block_h <= HIT_HI);
  assign in_perf  = (bus.block_h >= PERF_LO) && (bus.block_h <= PERF_HI);

  // Arrival bypasses the freeze so every block is accounted for exactly once.
  always_comb begin
    state_nx = state;
    hit_evt  = 1'b0;
    perf_evt = 1'b0;
    miss_evt = 1'b0;
    if (arrival) begin
      state_nx = S_ARMED;
      miss_evt = (state == S_ARMED);
    end else if (!frz && state == S_ARMED) begin
      if (bus.block_h > HIT_HI) begin
        state_nx = S_JUDGED;
        miss_evt = 1'b1;
      end else if (key_rise) begin
        state_nx = S_JUDGED;
        hit_evt  = in_hit;
        perf_evt = in_hit && in_perf;
        miss_evt = !in_hit;
      end
    end
  end

  always_comb begin
    score_sum = {1'b0, score_q} + (perf_evt ? 17'd2 : 17'd1);
    score_nx  = score_q;
    combo_nx  = combo_q;
    if (miss_evt) begin
      combo_nx = 8'd0;
    end else if (hit_evt) begin
      score_nx = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      combo_nx = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
    end
    max_nx = (combo_nx > max_q) ? combo_nx : max_q;
  end

  // Synchronizer and prev_h keep tracking during a freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      prev_h  <= BOTTOM;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      hit_q   <= 1'b0;
      perf_q  <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= 16'd0;
      combo_q <= 8'd0;
      max_q   <= 8'd0;
    end else if (bus.restart) begin
      state   <= S_IDLE;
      prev_h  <= BOTTOM;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      hit_q   <= 1'b0;
      perf_q  <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= 16'd0;
      combo_q <= 8'd0;
      max_q   <= 8'd0;
    end else begin
      state   <= state_nx;
      prev_h  <= bus.block_h;
      s1      <= bus.key;
      s2      <= s1;
      s3      <= s2;
      hit_q   <= hit_evt;
      perf_q  <= perf_evt;
      miss_q  <= miss_evt & ~frz;
      score_q <= score_nx;
      combo_q <= combo_nx;
      max_q   <= max_nx;
    end
  end

  assign bus.hit_pulse     = hit_q;
  assign bus.perfect_pulse = perf_q;
  assign bus.miss_pulse    = miss_q;
  assign bus.score         = score_q;
  assign bus.combo         = combo_q;
  assign bus.max_combo     = max_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// tb/tb_lane_hit_judge.sv - randomized and directed bench for lane_hit_judge against a behavioural model
module tb_lane_hit_judge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lane_hit_judge_if bus();

  lane_hit_judge dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Model: a block is either awaiting its verdict or not; key history by edge.
  bit m_armed = 1'b0;
  int m_prev = 720;
  bit k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;
  int m_score = 0, m_combo = 0, m_max = 0;
  bit e_hit = 1'b0, e_perf = 1'b0, e_miss = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int h;
    bit rise, arr, hit, perf, miss, frz;
    if (!rst_n || bus.restart) begin
      m_armed = 0; m_prev = 720; k1 = 0; k2 = 0; k3 = 0;
      m_score = 0; m_combo = 0; m_max = 0;
      e_hit = 0; e_perf = 0; e_miss = 0;
    end else begin
      h = int'(bus.block_h);
      frz = bus.stop_or_endgame;
      rise = k2 && !k3;
      arr = (h == 120) && (m_prev != 120);
      hit = 0; perf = 0; miss = 0;
      if (arr) begin
        miss = m_armed;
        m_armed = 1;
      end else if (!frz && m_armed) begin
        if (h > 700) begin
          miss = 1; m_armed = 0;
        end else if (rise) begin
          m_armed = 0;
          if (h < 600) miss = 1;
          else begin
            hit = 1;
            perf = (h >= 640 && h <= 670);
          end
        end
      end
      if (miss) m_combo = 0;
      if (hit) begin
        m_combo = (m_combo + 1 > 255) ? 255 : m_combo + 1;
        m_score = m_score + (perf ? 2 : 1);
        if (m_score > 65535) m_score = 65535;
      end
      if (m_combo > m_max) m_max = m_combo;
      e_hit = hit; e_perf = perf; e_miss = miss && !frz;
      k3 = k2; k2 = k1; k1 = bus.key;
      m_prev = h;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hit_pulse", int'(bus.hit_pulse), int'(e_hit));
      chk("perfect_pulse", int'(bus.perfect_pulse), int'(e_perf));
      chk("miss_pulse", int'(bus.miss_pulse), int'(e_miss));
      chk("score", int'(bus.score), m_score);
      chk("combo", int'(bus.combo), m_combo);
      chk("max_combo", int'(bus.max_combo), m_max);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  int n_hit = 0, n_perf = 0, n_miss = 0;
  always @(negedge clk) begin
    n_hit  += int'(bus.hit_pulse);
    n_perf += int'(bus.perfect_pulse);
    n_miss += int'(bus.miss_pulse);
  end

  // Arrival, then hold block_h at h with a fresh press so the verdict uses h.
  task automatic judge(int h);
    bus.block_h = 10'd120; step();
    bus.block_h = 10'(h); bus.key = 1'b1;
    step(); step(); step();
    bus.key = 1'b0; step();
  endtask

  initial begin
    int miss_at, nm, h, press_at, plen, abort_at, sz;
    bit abort;
    bus.restart = 0; bus.stop_or_endgame = 0; bus.block_h = 10'd720; bus.key = 0;
    #1 cmp_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    chk("rst_score", int'(bus.score), 0);
    chk("rst_pulses", int'({bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse}), 0);

    nm = 0; miss_at = -1;
    for (int i = 120; i <= 720; i++) begin
      bus.block_h = 10'(i); step();
      if (bus.miss_pulse) begin nm++; miss_at = i; end
    end
    chk("ramp_miss_count", nm, 1);
    chk("ramp_miss_at", miss_at, 701);
    chk("ramp_combo", int'(bus.combo), 0);

    judge(650);
    chk("perf_score", int'(bus.score), 2);
    chk("perf_combo", int'(bus.combo), 1);
    chk("perf_max", int'(bus.max_combo), 1);
    nm = n_perf;
    judge(600); chk("lo_edge_score", int'(bus.score), 3);
    judge(700); chk("hi_edge_score", int'(bus.score), 4);
    chk("edge_no_perfect", n_perf - nm, 0);
    nm = n_miss;
    judge(599);
    chk("early_miss", n_miss - nm, 1);
    chk("early_combo", int'(bus.combo), 0);
    chk("early_max", int'(bus.max_combo), 3);

    bus.restart = 1; step(); bus.restart = 0;
    for (int i = 0; i < 256; i++) judge(650);
    chk("sat_combo", int'(bus.combo), 255);
    chk("sat_max", int'(bus.max_combo), 255);
    chk("sat_score", int'(bus.score), 512);
    judge(720);
    chk("sat_miss_combo", int'(bus.combo), 0);
    chk("sat_miss_max", int'(bus.max_combo), 255);

    bus.block_h = 10'd120; step();
    bus.block_h = 10'd450; step();
    bus.block_h = 10'd120; step();
    chk("rearm_miss", int'(bus.miss_pulse), 1);
    bus.block_h = 10'd650; bus.key = 1; step(); step(); step();
    chk("rearm_hit", int'(bus.hit_pulse), 1);
    bus.key = 0; step();

    bus.block_h = 10'd120; step();
    bus.block_h = 10'd500; bus.stop_or_endgame = 1; bus.key = 1;
    for (int i = 0; i < 5; i++) step();
    bus.stop_or_endgame = 0; bus.block_h = 10'd650;
    nm = n_hit + n_miss;
    for (int i = 0; i < 4; i++) step();
    chk("held_key_no_verdict", n_hit + n_miss - nm, 0);
    bus.key = 0; bus.block_h = 10'd701; step(); step();
    chk("held_then_late_miss", n_hit + n_miss - nm, 1);

    bus.restart = 1; step(); bus.restart = 0;
    for (int i = 0; i < 5; i++) judge(650);
    chk("pre_restart_score", int'(bus.score), 10);
    bus.block_h = 10'd120; step();
    bus.block_h = 10'd400; step();
    bus.restart = 1; step(); bus.restart = 0;
    chk("restart_score", int'(bus.score), 0);
    chk("restart_max", int'(bus.max_combo), 0);
    nm = n_miss;
    bus.block_h = 10'd701; step(); step();
    chk("restart_idle", n_miss - nm, 0);

    judge(650); judge(650);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("async_score", int'(bus.score), 0);
    chk("async_combo", int'(bus.combo), 0);
    step(); rst_n = 1'b1; bus.block_h = 10'd720; step();

    for (int b = 0; b < 300; b++) begin
      bus.block_h = 10'd120;
      bus.stop_or_endgame = ($urandom_range(0, 15) == 0);
      step();
      h = 120;
      press_at = $urandom_range(10, 45);
      plen = $urandom_range(1, 5);
      abort = ($urandom_range(0, 7) == 0);
      abort_at = $urandom_range(1, 30);
      for (int c = 0; c < 70; c++) begin
        if (abort && c == abort_at) break;
        sz = $urandom_range(1, 25);
        h = (h + sz > 720) ? 720 : h + sz;
        bus.block_h = 10'(h);
        bus.key = (c >= press_at) && (c < press_at + plen);
        bus.stop_or_endgame = ($urandom_range(0, 15) == 0);
        bus.restart = ($urandom_range(0, 199) == 0);
        step();
        if (h == 720 && c > press_at + plen + 3) break;
      end
      bus.key = 0; bus.stop_or_endgame = 0; bus.restart = 0;
    end
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
